// File: rtl/mem_access_pkg.sv
// mem_access_pkg: shared encodings, FSM state and registered-op record for mem_access.
package mem_access_pkg;
  localparam logic [1:0] MW_NONE = 2'b00;
  localparam logic [1:0] MW_BYTE = 2'b01;
  localparam logic [1:0] MW_HALF = 2'b10;
  localparam logic [1:0] MW_WORD = 2'b11;
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  typedef enum logic {S_IDLE, S_REQ} state_t;
  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [3:0]  wstrb;
    logic [31:0] wdata;
    logic [4:0]  rd;
    logic [2:0]  funct3;
    logic        memtoreg;
    logic        regwrite;
  } op_t;
  // Loads share the MemWrite size encoding so one alignment check covers both.
  function automatic logic [1:0] load_size(input logic [2:0] f3);
    return f3[1:0] == 2'b00 ? MW_BYTE : f3[1:0] == 2'b01 ? MW_HALF : MW_WORD;
  endfunction
endpackage

// File: rtl/mem_access_load_align.sv
// load_align: extracts the addressed byte/half from a read word and extends it per funct3.
module load_align
  import mem_access_pkg::*;
(
  input  logic [31:0] rdata_i,
  input  logic [1:0]  addr_i,
  input  logic [2:0]  funct3_i,
  output logic [31:0] result_o
);
  logic [31:0] sh;
  assign sh = rdata_i >> {addr_i, 3'b000};
  always_comb
    result_o = funct3_i == F3_LB  ? {{24{sh[7]}}, sh[7:0]} :
               funct3_i == F3_LH  ? {{16{sh[15]}}, sh[15:0]} :
               funct3_i == F3_LW  ? rdata_i :
               funct3_i == F3_LBU ? {24'd0, sh[7:0]} :
               funct3_i == F3_LHU ? {16'd0, sh[15:0]} : rdata_i;
endmodule

// File: rtl/mem_access.sv
// mem_access: MEM stage that issues one data-memory request per op and pulses a write-back result.
module mem_access
  import mem_access_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        ex_valid,
  input  logic [4:0]  rd_in,
  input  logic [2:0]  funct3_in,
  input  logic [31:0] alu_result_in,
  input  logic [31:0] store_data_in,
  input  logic        MemREAD_in,
  input  logic [1:0]  MemWrite_in,
  input  logic        MemtoReg_in,
  input  logic        RegWrite_in,
  output logic        stall_out,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_wstrb,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata,
  output logic        wb_valid,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data,
  output logic        wb_RegWrite,
  output logic        misalign_err
);
  state_t      state_q, state_d;
  op_t         op_q, op_d;
  logic        wb_valid_q, wb_valid_d, wb_rw_q, wb_rw_d, mis_q, mis_d;
  logic [4:0]  wb_rd_q, wb_rd_d;
  logic [31:0] wb_data_q, wb_data_d, load_res, st_wdata;
  logic [3:0]  st_wstrb;
  logic [1:0]  sz;
  logic        is_store, is_load, mis;
  load_align u_load_align (
    .rdata_i  (dmem_rdata),
    .addr_i   (op_q.addr[1:0]),
    .funct3_i (op_q.funct3),
    .result_o (load_res)
  );
  assign is_store = MemWrite_in != MW_NONE;
  assign is_load  = MemREAD_in && !is_store;
  assign sz       = is_store ? MemWrite_in : load_size(funct3_in);
  assign mis      = (sz == MW_HALF && alu_result_in[0]) || (sz == MW_WORD && alu_result_in[1:0] != 2'b00);
  assign st_wstrb = MemWrite_in == MW_BYTE ? 4'b0001 << alu_result_in[1:0] :
                    MemWrite_in == MW_HALF ? 4'b0011 << alu_result_in[1:0] :
                    MemWrite_in == MW_WORD ? 4'b1111 : 4'b0000;
  assign st_wdata = MemWrite_in == MW_BYTE ? {4{store_data_in[7:0]}} :
                    MemWrite_in == MW_HALF ? {2{store_data_in[15:0]}} :
                    MemWrite_in == MW_WORD ? store_data_in : 32'd0;
  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    wb_valid_d = 1'b0;
    mis_d      = 1'b0;
    wb_rd_d    = wb_rd_q;
    wb_data_d  = wb_data_q;
    wb_rw_d    = wb_rw_q;
    if (state_q == S_IDLE && ex_valid) begin
      if (!(is_store || is_load) || mis) begin
        wb_valid_d = 1'b1;
        mis_d      = is_store || is_load;
        wb_rd_d    = rd_in;
        wb_data_d  = alu_result_in;
        wb_rw_d    = RegWrite_in && !(is_store || is_load);
      end else begin
        state_d = S_REQ;
        op_d    = '{we: is_store, addr: alu_result_in, wstrb: st_wstrb, wdata: st_wdata, rd: rd_in,
                    funct3: funct3_in, memtoreg: MemtoReg_in, regwrite: RegWrite_in && !is_store};
      end
    end else if (state_q == S_REQ && dmem_ack) begin
      state_d    = S_IDLE;
      wb_valid_d = 1'b1;
      wb_rd_d    = op_q.rd;
      wb_data_d  = op_q.memtoreg ? load_res : op_q.addr;
      wb_rw_d    = op_q.regwrite;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      op_q       <= '0;
      wb_valid_q <= 1'b0;
      mis_q      <= 1'b0;
      wb_rd_q    <= 5'd0;
      wb_data_q  <= 32'd0;
      wb_rw_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      wb_valid_q <= wb_valid_d;
      mis_q      <= mis_d;
      wb_rd_q    <= wb_rd_d;
      wb_data_q  <= wb_data_d;
      wb_rw_q    <= wb_rw_d;
    end
  end
  assign stall_out    = state_q == S_REQ;
  assign dmem_req     = state_q == S_REQ;
  assign dmem_we      = dmem_req && op_q.we;
  assign dmem_addr    = {op_q.addr[31:2], 2'b00};
  assign dmem_wstrb   = op_q.wstrb;
  assign dmem_wdata   = op_q.wdata;
  assign wb_valid     = wb_valid_q;
  assign wb_rd        = wb_rd_q;
  assign wb_data      = wb_data_q;
  assign wb_RegWrite  = wb_rw_q;
  assign misalign_err = mis_q;
endmodule

// File: tb/tb_mem_access.sv
// tb_mem_access: directed self-checking bench for mem_access.
module tb_mem_access;
  logic        clk = 1'b0, rst, ex_valid, MemREAD_in, MemtoReg_in, RegWrite_in, dmem_ack;
  logic [4:0]  rd_in;
  logic [2:0]  funct3_in;
  logic [31:0] alu_result_in, store_data_in, dmem_rdata;
  logic [1:0]  MemWrite_in;
  logic        stall_out, dmem_req, dmem_we, wb_valid, wb_RegWrite, misalign_err;
  logic [31:0] dmem_addr, dmem_wdata, wb_data;
  logic [3:0]  dmem_wstrb;
  logic [4:0]  wb_rd;
  int vectors = 0, miscompares = 0;
  mem_access dut (
    .clk(clk), .rst(rst), .ex_valid(ex_valid), .rd_in(rd_in), .funct3_in(funct3_in),
    .alu_result_in(alu_result_in), .store_data_in(store_data_in), .MemREAD_in(MemREAD_in),
    .MemWrite_in(MemWrite_in), .MemtoReg_in(MemtoReg_in), .RegWrite_in(RegWrite_in),
    .stall_out(stall_out), .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wstrb(dmem_wstrb), .dmem_wdata(dmem_wdata), .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data), .wb_RegWrite(wb_RegWrite),
    .misalign_err(misalign_err)
  );
  always #5 clk = ~clk;
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic idle_inputs();
    ex_valid = 0; rd_in = 0; funct3_in = 0; alu_result_in = 0; store_data_in = 0;
    MemREAD_in = 0; MemWrite_in = 2'b00; MemtoReg_in = 0; RegWrite_in = 0;
  endtask
  task automatic op(input logic rd_, input logic [1:0] mw, input logic [2:0] f3, input logic [31:0] a,
                    input logic [31:0] sd, input logic [4:0] rd, input logic m2r, input logic rw);
    ex_valid = 1; MemREAD_in = rd_; MemWrite_in = mw; funct3_in = f3; alu_result_in = a;
    store_data_in = sd; rd_in = rd; MemtoReg_in = m2r; RegWrite_in = rw;
  endtask
  initial begin
    rst = 1; dmem_ack = 0; dmem_rdata = 0; idle_inputs();
    step(); step();
    chk("rst_wb_valid", wb_valid, 0);
    chk("rst_stall", stall_out, 0);
    chk("rst_req", dmem_req, 0);
    chk("rst_we", dmem_we, 0);
    chk("rst_addr", dmem_addr, 0);
    chk("rst_wstrb", dmem_wstrb, 0);
    chk("rst_wdata", dmem_wdata, 0);
    chk("rst_wb_data", wb_data, 0);
    chk("rst_wb_rd", wb_rd, 0);
    chk("rst_mis", misalign_err, 0);
    rst = 0;
    // ALU op
    op(0, 2'b00, 3'b000, 32'h1234, 0, 5'd5, 0, 1);
    chk("alu_stall0", stall_out, 0);
    step(); idle_inputs();
    chk("alu_wb_valid", wb_valid, 1);
    chk("alu_wb_data", wb_data, 32'h1234);
    chk("alu_wb_rd", wb_rd, 5);
    chk("alu_wb_rw", wb_RegWrite, 1);
    chk("alu_stall1", stall_out, 0);
    chk("alu_req", dmem_req, 0);
    step();
    chk("alu_pulse", wb_valid, 0);
    // LB at 0x103, ack on third request cycle
    op(1, 2'b00, 3'b000, 32'h103, 0, 5'd7, 1, 1);
    step(); idle_inputs();
    chk("lb_req", dmem_req, 1);
    chk("lb_we", dmem_we, 0);
    chk("lb_addr", dmem_addr, 32'h100);
    chk("lb_stall1", stall_out, 1);
    step();
    chk("lb_stall2", stall_out, 1);
    chk("lb_nowb", wb_valid, 0);
    step();
    chk("lb_stall3", stall_out, 1);
    chk("lb_addr_hold", dmem_addr, 32'h100);
    dmem_ack = 1; dmem_rdata = 32'h80AABBCC;
    step(); dmem_ack = 0;
    chk("lb_wb_valid", wb_valid, 1);
    chk("lb_wb_data", wb_data, 32'hFFFFFF80);
    chk("lb_wb_rd", wb_rd, 7);
    chk("lb_wb_rw", wb_RegWrite, 1);
    chk("lb_stall_end", stall_out, 0);
    chk("lb_req_end", dmem_req, 0);
    // SH at 0x102, immediate ack
    op(0, 2'b10, 3'b000, 32'h102, 32'hDEADBEEF, 5'd2, 0, 1);
    step(); idle_inputs();
    chk("sh_req", dmem_req, 1);
    chk("sh_we", dmem_we, 1);
    chk("sh_addr", dmem_addr, 32'h100);
    chk("sh_wstrb", dmem_wstrb, 4'b1100);
    chk("sh_wdata", dmem_wdata, 32'hBEEFBEEF);
    dmem_ack = 1;
    step(); dmem_ack = 0;
    chk("sh_wb_valid", wb_valid, 1);
    chk("sh_wb_rw", wb_RegWrite, 0);
    chk("sh_stall_end", stall_out, 0);
    // Misaligned LW at 0x101
    op(1, 2'b00, 3'b010, 32'h101, 0, 5'd4, 1, 1);
    step(); idle_inputs();
    chk("lw_mis_req", dmem_req, 0);
    chk("lw_mis_wb_valid", wb_valid, 1);
    chk("lw_mis_err", misalign_err, 1);
    chk("lw_mis_rw", wb_RegWrite, 0);
    chk("lw_mis_stall", stall_out, 0);
    step();
    chk("lw_mis_pulse", misalign_err, 0);
    chk("lw_mis_wb_pulse", wb_valid, 0);
    // Ack in IDLE is ignored
    dmem_ack = 1;
    step(); dmem_ack = 0;
    chk("idle_ack_wb", wb_valid, 0);
    chk("idle_ack_stall", stall_out, 0);
    // SB with MemREAD also set: store wins, word-load misalignment irrelevant
    op(1, 2'b01, 3'b010, 32'h101, 32'h000000A5, 5'd6, 0, 1);
    step(); idle_inputs();
    chk("sb_req", dmem_req, 1);
    chk("sb_we", dmem_we, 1);
    chk("sb_wstrb", dmem_wstrb, 4'b0010);
    chk("sb_wdata", dmem_wdata, 32'hA5A5A5A5);
    dmem_ack = 1;
    step(); dmem_ack = 0;
    chk("sb_wb_valid", wb_valid, 1);
    chk("sb_wb_rw", wb_RegWrite, 0);
    chk("sb_mis", misalign_err, 0);
    // Reset while a load is pending
    op(1, 2'b00, 3'b010, 32'h200, 0, 5'd8, 1, 1);
    step(); idle_inputs();
    chk("rstp_req", dmem_req, 1);
    step();
    rst = 1;
    step(); rst = 0;
    chk("rstp_req_drop", dmem_req, 0);
    chk("rstp_stall", stall_out, 0);
    chk("rstp_wb", wb_valid, 0);
    dmem_ack = 1;
    step(); dmem_ack = 0;
    chk("rstp_no_wb", wb_valid, 0);
    op(0, 2'b00, 3'b000, 32'h55, 0, 5'd3, 0, 1);
    step(); idle_inputs();
    chk("rstp_alu_valid", wb_valid, 1);
    chk("rstp_alu_data", wb_data, 32'h55);
    chk("rstp_alu_rd", wb_rd, 3);
    // LHU at 0x102 then an ALU op held by stall (k=2)
    op(1, 2'b00, 3'b101, 32'h102, 0, 5'd10, 1, 1);
    step();
    op(0, 2'b00, 3'b000, 32'h77, 0, 5'd9, 0, 1);
    chk("b2b_stall1", stall_out, 1);
    chk("b2b_addr", dmem_addr, 32'h100);
    step();
    chk("b2b_stall2", stall_out, 1);
    chk("b2b_nowb", wb_valid, 0);
    dmem_ack = 1; dmem_rdata = 32'h80011234;
    step(); dmem_ack = 0;
    chk("b2b_ld_valid", wb_valid, 1);
    chk("b2b_ld_data", wb_data, 32'h00008001);
    chk("b2b_ld_rd", wb_rd, 10);
    chk("b2b_stall_end", stall_out, 0);
    step(); idle_inputs();
    chk("b2b_alu_valid", wb_valid, 1);
    chk("b2b_alu_data", wb_data, 32'h77);
    chk("b2b_alu_rd", wb_rd, 9);
    chk("b2b_alu_req", dmem_req, 0);
    step();
    chk("b2b_pulse", wb_valid, 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/mem_access.md
MEM_ACCESS -- requirements
Module: mem_access

Interface
REQ-001 The interface SHALL have exactly these ports, one clock and a synchronous active-high reset:
- clk  in  1  sole clock, rising edge
- rst  in  1  synchronous, active-high reset
- ex_valid  in  1  EX result valid this cycle
- rd_in  in  5  destination register
- funct3_in  in  3  load size/sign: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU
- alu_result_in  in  32  ALU result, or byte address for memory ops
- store_data_in  in  32  rs2 data for stores
- MemREAD_in  in  1  load
- MemWrite_in  in  2  store size: 00 none, 01 byte, 10 half, 11 word
- MemtoReg_in  in  1  write-back selects load data
- RegWrite_in  in  1  write-back enable
- stall_out  out  1  block busy; upstream holds its inputs
- dmem_req  out  1  memory request
- dmem_we  out  1  request is a write
- dmem_addr  out  32  word-aligned address ({addr[31:2],2'b00})
- dmem_wstrb  out  4  byte enables
- dmem_wdata  out  32  lane-shifted store data
- dmem_ack  in  1  request completed; dmem_rdata valid for reads
- dmem_rdata  in  32  read word
- wb_valid  out  1  one-cycle write-back pulse
- wb_rd  out  5  destination register
- wb_data  out  32  write-back data
- wb_RegWrite  out  1  write-back enable
- misalign_err  out  1  pulses with wb_valid on a misaligned access

Function
REQ-002 The FSM SHALL have two states: IDLE and REQ.
REQ-003 In IDLE with ex_valid=1 and neither MemREAD_in nor MemWrite_in!=00, wb_valid SHALL be 1 in the next cycle, with wb_data=alu_result_in and wb_rd/wb_RegWrite taken from the inputs; the FSM stays in IDLE.
REQ-004 In IDLE with ex_valid=1 and an aligned memory op, the block SHALL register the op and enter REQ; if both MemREAD_in and MemWrite_in!=00 are set, the store SHALL take priority.
REQ-005 Alignment: a half access is misaligned when addr[0]=1; a word access is misaligned when addr[1:0]!=0.
REQ-006 A misaligned op SHALL issue no request and SHALL produce wb_valid=1, misalign_err=1 and wb_RegWrite=0 in the next cycle.
REQ-007 In REQ, dmem_req SHALL be held at 1 and dmem_addr/dmem_we/dmem_wstrb/dmem_wdata SHALL be held stable until the cycle in which dmem_ack=1.
REQ-008 On the dmem_ack cycle the FSM SHALL return to IDLE and wb_valid SHALL be 1 in the next cycle.
REQ-009 dmem_ack SHALL be ignored in IDLE.
REQ-010 Store strobes SHALL be:
- byte: 4'b0001<<addr[1:0], with data replicated to all byte lanes
- half: 4'b0011<<addr[1:0], with data replicated to both half-word lanes
- word: 4'b1111
REQ-011 A load SHALL extract the byte/half at addr[1:0] from dmem_rdata and sign- or zero-extend it per funct3 to produce wb_data.
REQ-012 A store SHALL produce wb_RegWrite=0.
REQ-013 wb_data SHALL be the load result when MemtoReg=1, and the registered ALU result otherwise.
REQ-014 stall_out SHALL be 1 exactly while the state is REQ, and 0 in IDLE.
REQ-015 ex_valid SHALL be ignored while the state is REQ.
REQ-016 Latency:
- non-memory op accepted at T: wb_valid at T+1
- memory op accepted at T: dmem_req from T+1; with ack at T+k, wb_valid at T+k+1 and a new op acceptable at T+k+1
REQ-017 wb_valid and misalign_err SHALL be single-cycle pulses; wb_rd, wb_data and wb_RegWrite SHALL be meaningful only when wb_valid=1.

Reset
REQ-018 While rst=1 at a clock edge, the block SHALL:
- set the state to IDLE
- drive dmem_req, dmem_we, wb_valid, wb_RegWrite, misalign_err and stall_out to 0
- drive dmem_addr, dmem_wstrb, dmem_wdata, wb_rd and wb_data to 0
REQ-019 Reset during REQ SHALL drop dmem_req in the following cycle and discard the pending op without producing wb_valid.

Structure
REQ-020 A shared package SHALL hold:
- the MemWrite encodings
- the funct3 load encodings
- the FSM state type
REQ-021 A combinational sub-module load_align (rdata, addr[1:0], funct3 -> 32-bit result) SHALL perform load extraction and extension.

Verification
REQ-022 The bench SHALL cover these directed scenarios:
- ALU op, alu_result_in=0x1234, rd=5, RegWrite=1 -> next cycle wb_valid=1, wb_data=0x1234, wb_rd=5, stall_out=0 throughout.
- LB at addr 0x103, with ack asserted 3 cycles after dmem_req rises and rdata=0x80AABBCC -> dmem_addr=0x100, stall_out high for 3 cycles, wb_data=0xFFFFFF80.
- SH at addr 0x102, data 0xDEADBEEF, with immediate ack -> dmem_we=1, wstrb=4'b1100, wdata=0xBEEFBEEF, wb_RegWrite=0.
- LW at addr 0x101 -> no dmem_req, next cycle wb_valid=1, misalign_err=1, wb_RegWrite=0.
- Load pending, with rst asserted before ack -> dmem_req=0 the cycle after reset, no wb_valid; a following ALU op completes normally.
- Back-to-back load then ALU op held by stall -> wb_valid for the load at T+k+1 and for the ALU op at T+k+2.
